// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO fed by bus writes, drained
// by a start/data/stop serializer at a fixed baud rate.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [7:0]                         data_in,
    input  logic                               clr_ovf,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               busy,
    output logic                               overflow,
    output logic                               UART_Tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BaudMax = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          last_tick;

    // A write is judged against the registered full flag, so a write that
    // coincides with a pop while full is still dropped.
    assign push = wr_en & ~full_q;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Occupancy and sticky overflow next-state; an overflow event beats a clear.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO pointers and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            full_q     <= (count_d == CW'(FIFO_DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_d;
        end
    end

    // Serializer next-state: pops in IDLE or on the last STOP cycle for gapless frames.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        last_tick = (baud_q == BaudMax);
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = StStart;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (last_tick) begin
                    state_d   = StData;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StData: begin
                if (last_tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StStop: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state being entered so UART_Tx is a clean register.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Serializer state; reset drives the line high immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle);
    assign UART_Tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    data_in;
    logic          clr_ovf;
    logic          full, empty, busy, overflow, tx;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    int peak  = 0;
    int w     = 0;
    int errs  = 0;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       clr;
        logic [2:0] cnt;
        logic       fl;
        logic       em;
        logic       ov;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .busy     (busy),
        .overflow (overflow),
        .UART_Tx  (tx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for a start bit, then checks all 40 line cycles of the frame.
    task automatic expect_frame(input logic [7:0] b, output int waited);
        logic [9:0] bits;
        int         nerr;
        bits   = {1'b1, b, 1'b0};
        waited = 0;
        while (tx !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        if (tx !== 1'b0) begin
            check($sformatf("start bit of frame %02h", b), 32'(tx), 32'd0);
            return;
        end
        nerr = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (tx !== bits[k / CPB]) nerr++;
            if (int'(count) > peak) peak = int'(count);
            tick();
        end
        check($sformatf("frame %02h bit errors", b), 32'(nerr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 8'h21, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h23, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h24, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h25, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h26, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};

        reset   = 1'b0;
        wr_en   = 1'b0;
        data_in = 8'h00;
        clr_ovf = 1'b0;
        repeat (3) tick();

        // Reset state
        check("reset tx", 32'(tx), 32'd1);
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Single byte: two-cycle latency to the start bit, busy drops 40 cycles later
        wr_en = 1'b1; data_in = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("a5 count after write", 32'(count), 32'd1);
        check("a5 empty after write", 32'(empty), 32'd0);
        check("a5 tx before pop", 32'(tx), 32'd1);
        tick();
        check("a5 start bit", 32'(tx), 32'd0);
        check("a5 busy", 32'(busy), 32'd1);
        check("a5 count after pop", 32'(count), 32'd0);
        expect_frame(8'hA5, w);
        check("a5 wait", 32'(w), 32'd0);
        check("a5 busy after frame", 32'(busy), 32'd0);
        check("a5 tx after frame", 32'(tx), 32'd1);

        // Back-to-back writes: simultaneous push/pop, gapless frames
        peak = 0;
        wr_en = 1'b1; data_in = 8'h00;
        tick();
        data_in = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("b2b count push+pop", 32'(count), 32'd1);
        expect_frame(8'h00, w);
        check("b2b first wait", 32'(w), 32'd0);
        expect_frame(8'hFF, w);
        check("b2b gap", 32'(w), 32'd0);
        check("b2b peak", 32'(peak), 32'd1);
        check("b2b empty", 32'(empty), 32'd1);

        // Overflow: table of writes/clears applied while 0x11 is on the line
        wr_en = 1'b1; data_in = 8'h11;
        tick();
        wr_en = 1'b0;
        tick();
        fork
            begin
                expect_frame(8'h11, w);
                check("ovf first wait", 32'(w), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    expect_frame(8'h21 + 8'(i), w);
                    check($sformatf("ovf frame %0d gap", i), 32'(w), 32'd0);
                end
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    wr_en   = vecs[i].wr;
                    data_in = vecs[i].d;
                    clr_ovf = vecs[i].clr;
                    tick();
                    check($sformatf("ovf row %0d {count,full,empty,ovf}", i),
                          32'({count, full, empty, overflow}),
                          32'({vecs[i].cnt, vecs[i].fl, vecs[i].em, vecs[i].ov}));
                end
                wr_en   = 1'b0;
                clr_ovf = 1'b0;
            end
        join
        errs = 0;
        for (int k = 0; k < 60; k++) begin
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
            tick();
        end
        check("ovf no extra frames", 32'(errs), 32'd0);
        check("ovf empty at end", 32'(empty), 32'd1);

        // Pointer wrap: ten bytes, one per frame
        peak = 0;
        for (int b = 1; b <= 10; b++) begin
            wr_en = 1'b1; data_in = 8'(b);
            tick();
            wr_en = 1'b0;
            if (int'(count) > peak) peak = int'(count);
            expect_frame(8'(b), w);
            check($sformatf("wrap byte %0d latency", b), 32'(w), 32'd1);
        end
        check("wrap peak", 32'(peak), 32'd1);

        // Reset mid-frame during data bit 0 of 0x3C with two bytes queued
        wr_en = 1'b1; data_in = 8'h3C;
        tick();
        data_in = 8'hAA;
        tick();
        data_in = 8'hBB;
        tick();
        wr_en = 1'b0;
        check("midrst queued", 32'(count), 32'd2);
        repeat (4) tick();
        check("midrst tx before reset", 32'(tx), 32'd0);
        check("midrst busy before reset", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst tx async", 32'(tx), 32'd1);
        check("midrst count", 32'(count), 32'd0);
        check("midrst empty", 32'(empty), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("midrst no frames after release", 32'(errs), 32'd0);
        check("midrst empty after release", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
